// File: rtl/exe_muldiv_unit_pkg.sv
// Shared encodings for the EXE-stage multiply/divide unit: op codes and FSM states.
package exe_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Ops that occupy the iterative core for WIDTH cycles.
  function automatic logic is_iter_op(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/exe_muldiv_unit_iter_core.sv
// Radix-2 datapath: shift-add multiply and restoring divide on operand magnitudes,
// with sign correction applied to the value produced by the current step.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic [WIDTH-1:0] o_res_hi,
  output logic [WIDTH-1:0] o_res_lo
);

  logic [WIDTH-1:0]   r_hi, r_lo, r_opnd;
  logic               r_is_div, r_neg_hi, r_neg_lo;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_nxt_hi, w_nxt_lo;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod;

  assign w_mag_a = (i_is_signed && i_src_a[WIDTH-1]) ? -i_src_a : i_src_a;
  assign w_mag_b = (i_is_signed && i_src_b[WIDTH-1]) ? -i_src_b : i_src_b;

  assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opnd};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_nxt_hi = w_sum[WIDTH:1];
    w_nxt_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      w_nxt_hi = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_nxt_lo = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end
  end

  // Divide by zero needs no special case: the remainder path reassembles the
  // dividend magnitude, the quotient fills with ones, and r_neg_lo stays clear.
  assign w_prod = {w_nxt_hi, w_nxt_lo};

  always_comb begin
    {o_res_hi, o_res_lo} = r_neg_lo ? -w_prod : w_prod;
    if (r_is_div) begin
      o_res_hi = r_neg_hi ? -w_nxt_hi : w_nxt_hi;
      o_res_lo = r_neg_lo ? -w_nxt_lo : w_nxt_lo;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // accumulators included, takes a defined value on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
    end else if (i_load) begin
      r_hi     <= '0;
      r_lo     <= i_is_div ? w_mag_a : w_mag_b;
      r_opnd   <= i_is_div ? w_mag_b : w_mag_a;
      r_is_div <= i_is_div;
      r_neg_hi <= i_is_div & i_is_signed & i_src_a[WIDTH-1];
      r_neg_lo <= i_is_signed & (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]) & (~i_is_div | (|i_src_b));
    end else if (i_step) begin
      r_hi <= w_nxt_hi;
      r_lo <= w_nxt_lo;
    end
  end

endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage multiply/divide unit: HI/LO registers, IDLE/RUN sequencer for the
// iterative core, MF*/MT* access and the pipeline stall request.
module exe_muldiv_unit
  import exe_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_t        r_state, w_next;
  md_op_t           w_op;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_hi, r_lo, w_res_hi, w_res_lo;
  logic             w_accept, w_load, w_step, w_write;

  assign w_op      = md_op_t'(op);
  assign busy      = (r_state == ST_RUN);
  assign w_accept  = start & ~busy & ~flush;
  assign stall_req = start & busy & ~flush;
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_write = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && is_iter_op(w_op)) begin
          w_load = 1'b1;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A flush, even on the last step, abandons the result.
        if (flush) begin
          w_next = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == CNT_LAST) begin
            w_write = 1'b1;
            w_next  = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mf_result = '0;
    if (start && !busy) begin
      if (w_op == MD_MFHI) mf_result = r_hi;
      if (w_op == MD_MFLO) mf_result = r_lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      if (w_load)      r_count <= '0;
      else if (w_step) r_count <= r_count + 1'b1;
      if (w_write) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_accept) begin
        if (w_op == MD_MTHI) r_hi <= src_a;
        if (w_op == MD_MTLO) r_lo <= src_a;
      end
    end
  end

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_is_div   ((w_op == MD_DIV) || (w_op == MD_DIVU)),
    .i_is_signed((w_op == MD_MULT) || (w_op == MD_DIV)),
    .i_src_a    (src_a),
    .i_src_b    (src_b),
    .o_res_hi   (w_res_hi),
    .o_res_lo   (w_res_lo)
  );

endmodule
